frac_out_collector: RTL and testbench
=====================================

# frac_out_collector

Downstream stage of the fractional-order derivative operator. Captures each new Q8.24 derivative sample, announced by a toggle on the indicator line, and keeps a power-of-two sliding window. It emits the window's moving average through a small valid/ready output FIFO. This turns the 100 Hz derivative stream into a smoothed, back-pressurable stream for logging or control.

## Interface
- `WIN_LOG2`, 3: log2 of the averaging window length (window = 8 samples).
- `FIFO_LOG2`, 2: log2 of the output FIFO depth (depth = 4).
- `clk_100HZ`  in  1  — sample clock; all logic updates on its rising edge.
- `Rst`  in  1  — synchronous reset, active-high.
- `Sample_i`  in  32  — signed Q8.24 derivative output from the upstream stage.
- `SampleInd_i`  in  1  — toggle indicator; each level change marks one new sample on `Sample_i`.
- `Avg_o`  out  32  — signed Q8.24 average at the FIFO head; 0 when the FIFO is empty.
- `AvgValid_o`  out  1  — FIFO non-empty.
- `AvgReady_i`  in  1  — consumer accepts `Avg_o`.
- `Overflow_o`  out  1  — sticky flag; an average was dropped because the FIFO was full.
- `Fill_o`  out  FIFO_LOG2+1  — current FIFO occupancy, 0..2^FIFO_LOG2.

## Operation
- **Edge detect:** `ind_q` registers `SampleInd_i`; event = `SampleInd_i ^ ind_q`. During reset, `ind_q` loads `SampleInd_i`, so no spurious event occurs on release.
- **Window:** 2^WIN_LOG2-entry circular buffer, write pointer wraps modulo the window length.
  - Running sum is signed, 32+WIN_LOG2 bits; it never overflows.
  - On each event: sum ← sum + `Sample_i` − oldest entry; oldest entry is overwritten; pointer advances.
- **Average:** sum >>> WIN_LOG2, an arithmetic shift (floor toward −∞), truncated to 32 bits. The result is exact in range.
- **FSM (with warm-up macro):**
  - WARMUP: counts events; the event that fills the window moves the FSM to RUN, and that fill event is the first to push.
  - RUN: every event pushes one average.
  - Reset → WARMUP with buffer, sum and count cleared to 0.
- **FIFO:**
  - Pop occurs when `AvgValid_o` && `AvgReady_i`.
  - A push is accepted when not full, or when a pop happens in the same cycle (simultaneous push and pop when full keeps Fill unchanged).
  - A push while full with no pop is dropped and sets `Overflow_o`.
  - Read order is strictly FIFO.
- **Overflow_o:** cleared only by `Rst`.
- **Reset values:** `Avg_o`=0, `AvgValid_o`=0, `Overflow_o`=0, `Fill_o`=0.
- **Reset mid-operation:** FIFO contents, window and FSM are discarded. A full refill is required before the next output.

## Timing
- **E0:** event sampled at edge E0; buffer and sum update at E0.
- **E1:** average computed from the registered sum and pushed at E1. `AvgValid_o`/`Avg_o` are visible after E1, so latency is 2 edges from the toggle being sampled.
- **Event rate:** at most one event per clock. Consecutive-cycle toggles are each captured.
- **Outputs:** all outputs are registered; `Avg_o` changes only on push-to-empty or pop.
- **Rst:** `Rst` overrides every other input in the same cycle.

## Configuration
- `FRAC_COLLECT_WARMUP_EN` defined: WARMUP/RUN FSM is active; no average is pushed until 2^WIN_LOG2 samples have been captured.
- Undefined:
  - No FSM; every event from the first pushes an average.
  - The window starts zero-filled, so early averages include zeros (divided by the full window length).

## Test plan
- **Warm-up:** macro on, `AvgReady_i`=1, 8 toggles with `Sample_i`=16777216 (1.0).
  - No `AvgValid_o` for samples 1–7.
  - One push at sample 8 with `Avg_o`=16777216.
- **Negative update:** 8 samples of −49028 → `Avg_o`=−49028. One more sample of −49036 → `Avg_o`=−49029.
- **Floor rounding:** full window of 0, then one sample of −1 → `Avg_o`=−1 (not 0).
- **Backpressure:** `AvgReady_i`=0, 6 post-warm-up averages with values 1..6.
  - `Fill_o`=4, `Overflow_o`=1.
  - Drain yields 1,2,3,4 in order; `Overflow_o` stays 1.
- **Reset mid-operation:** `Rst` high for 1 cycle while `AvgValid_o`=1 → all outputs 0; the next 7 toggles produce no output.
- **Macro off:** first sample 16777216 → `Avg_o`=2097152 after 2 edges.

Source files
------------

// File: rtl/frac_out_collector.sv
// Moving-average collector for the toggle-announced Q8.24 derivative stream, with a valid/ready output FIFO.
// Optional macro FRAC_COLLECT_WARMUP_EN holds off output until the averaging window has been filled once.
module frac_out_collector #(
    parameter int WIN_LOG2  = 3,
    parameter int FIFO_LOG2 = 2
) (
    input  logic                  clk_100HZ,
    input  logic                  Rst,
    input  logic signed [31:0]    Sample_i,
    input  logic                  SampleInd_i,
    output logic signed [31:0]    Avg_o,
    output logic                  AvgValid_o,
    input  logic                  AvgReady_i,
    output logic                  Overflow_o,
    output logic [FIFO_LOG2:0]    Fill_o
);

    localparam int WIN   = 1 << WIN_LOG2;
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int SUM_W = 32 + WIN_LOG2;
    localparam int FW    = FIFO_LOG2 + 1;

    logic                       ind_q;
    logic                       sample_evt;
    logic signed [31:0]         win_mem [WIN];
    logic [WIN_LOG2-1:0]        win_ptr;
    logic signed [SUM_W-1:0]    win_sum;
    logic                       push_req;
    logic                       push_q;
    logic signed [31:0]         avg_new;

    assign sample_evt = SampleInd_i ^ ind_q;

    // The sum is already registered when push_q fires, so the average reflects the newest sample.
    assign avg_new = 32'(win_sum >>> WIN_LOG2);

    always_ff @(posedge clk_100HZ) begin
        if (Rst) begin
            ind_q   <= SampleInd_i;
            win_ptr <= '0;
            win_sum <= '0;
            push_q  <= 1'b0;
            // NOTE: the window must be reset because its zero contents feed the early averages;
            // the FIFO storage below is never read before being written, so it is left unreset.
            for (int i = 0; i < WIN; i++) begin
                win_mem[i] <= '0;
            end
        end else begin
            ind_q  <= SampleInd_i;
            push_q <= push_req;
            if (sample_evt) begin
                win_mem[win_ptr] <= Sample_i;
                win_ptr          <= win_ptr + WIN_LOG2'(1);
                win_sum          <= win_sum + SUM_W'(Sample_i) - SUM_W'(win_mem[win_ptr]);
            end
        end
    end

`ifdef FRAC_COLLECT_WARMUP_EN
    typedef enum logic {
        S_WARMUP = 1'b0,
        S_RUN    = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [WIN_LOG2-1:0]    warm_cnt_q;
    logic [WIN_LOG2-1:0]    warm_cnt_d;

    always_ff @(posedge clk_100HZ) begin
        if (Rst) begin
            state_q    <= S_WARMUP;
            warm_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        push_req   = 1'b0;
        case (state_q)
            S_WARMUP: begin
                if (sample_evt) begin
                    if (warm_cnt_q == WIN_LOG2'(WIN - 1)) begin
                        state_d  = S_RUN;
                        push_req = 1'b1;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WIN_LOG2'(1);
                    end
                end
            end
            S_RUN:   push_req = sample_evt;
            default: state_d  = S_WARMUP;
        endcase
    end
`else
    assign push_req = sample_evt;
`endif

    logic signed [31:0]     fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0]   rd_ptr;
    logic [FIFO_LOG2-1:0]   wr_ptr;
    logic [FIFO_LOG2-1:0]   rd_ptr_nxt;
    logic [FIFO_LOG2:0]     fill_q;
    logic [FIFO_LOG2:0]     fill_after_pop;
    logic [FIFO_LOG2:0]     fill_nxt;
    logic                   fifo_full;
    logic                   pop;
    logic                   push_ok;
    logic signed [31:0]     head_nxt;

    assign fifo_full      = (fill_q == FW'(DEPTH));
    assign pop            = AvgValid_o & AvgReady_i;
    assign push_ok        = push_q & (~fifo_full | pop);
    assign rd_ptr_nxt     = pop ? rd_ptr + FIFO_LOG2'(1) : rd_ptr;
    assign fill_after_pop = fill_q - FW'(pop);
    assign fill_nxt       = fill_after_pop + FW'(push_ok);
    assign Fill_o         = fill_q;

    // The head only changes when the FIFO goes empty, a pop exposes the next entry, or a push lands in an empty FIFO.
    always_comb begin
        head_nxt = '0;
        if (fill_nxt != '0) begin
            if (fill_after_pop == '0) begin
                head_nxt = avg_new;
            end else begin
                head_nxt = fifo_mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk_100HZ) begin
        if (push_ok && !Rst) begin
            fifo_mem[wr_ptr] <= avg_new;
        end
    end

    always_ff @(posedge clk_100HZ) begin
        if (Rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_q     <= '0;
            Avg_o      <= '0;
            AvgValid_o <= 1'b0;
            Overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_LOG2'(1);
            end
            rd_ptr     <= rd_ptr_nxt;
            fill_q     <= fill_nxt;
            Avg_o      <= head_nxt;
            AvgValid_o <= (fill_nxt != '0);
            if (push_q && !push_ok) begin
                Overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frac_out_collector.sv
// Directed self-checking bench for frac_out_collector; expectations follow FRAC_COLLECT_WARMUP_EN when defined.
module tb_frac_out_collector;

    localparam int ONE = 16777216;

    logic               clk_100HZ;
    logic               Rst;
    logic signed [31:0] Sample_i;
    logic               SampleInd_i;
    logic signed [31:0] Avg_o;
    logic               AvgValid_o;
    logic               AvgReady_i;
    logic               Overflow_o;
    logic [2:0]         Fill_o;

    int total;
    int bad;

    frac_out_collector #(.WIN_LOG2(3), .FIFO_LOG2(2)) dut (
        .clk_100HZ   (clk_100HZ),
        .Rst         (Rst),
        .Sample_i    (Sample_i),
        .SampleInd_i (SampleInd_i),
        .Avg_o       (Avg_o),
        .AvgValid_o  (AvgValid_o),
        .AvgReady_i  (AvgReady_i),
        .Overflow_o  (Overflow_o),
        .Fill_o      (Fill_o)
    );

    initial clk_100HZ = 1'b0;
    always #5 clk_100HZ = ~clk_100HZ;

    typedef struct {
        int sample;
        bit chk;
        int exp_valid;
        int exp_avg;
        int exp_fill;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input int s);
        @(negedge clk_100HZ);
        Sample_i    = s;
        SampleInd_i = ~SampleInd_i;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk_100HZ);
    endtask

    // Pulses Rst for one cycle while flipping the indicator, which must not count as a sample.
    task automatic do_reset(input string tag);
        @(negedge clk_100HZ);
        Rst         = 1'b1;
        SampleInd_i = ~SampleInd_i;
        @(negedge clk_100HZ);
        Rst = 1'b0;
        check({tag, "_rst_valid"}, AvgValid_o, 0);
        check({tag, "_rst_avg"}, Avg_o, 0);
        check({tag, "_rst_ovf"}, Overflow_o, 0);
        check({tag, "_rst_fill"}, Fill_o, 0);
        settle(2);
        check({tag, "_no_spurious"}, AvgValid_o, 0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        Rst         = 1'b1;
        Sample_i    = '0;
        SampleInd_i = 1'b0;
        AvgReady_i  = 1'b1;

        // Rows 0-7: eight samples of 1.0 starting from an empty window.
        for (int i = 0; i < 8; i++) begin
`ifdef FRAC_COLLECT_WARMUP_EN
            vecs[i] = '{ONE, 1'b1, (i == 7) ? 1 : 0, (i == 7) ? ONE : 0, (i == 7) ? 1 : 0};
`else
            vecs[i] = '{ONE, 1'b1, 1, (i + 1) * 2097152, 1};
`endif
        end
        for (int i = 8; i < 15; i++) vecs[i] = '{-49028, 1'b0, 0, 0, 0};
        vecs[15] = '{-49028, 1'b1, 1, -49028, 1};
        vecs[16] = '{-49036, 1'b1, 1, -49029, 1};
        for (int i = 17; i < 24; i++) vecs[i] = '{0, 1'b0, 0, 0, 0};
        vecs[24] = '{0, 1'b1, 1, 0, 1};
        vecs[25] = '{-1, 1'b1, 1, -1, 1};

        settle(3);
        do_reset("init");

        for (int i = 0; i < 26; i++) begin
            send(vecs[i].sample);
            settle(2);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_valid", i), AvgValid_o, vecs[i].exp_valid);
                check($sformatf("vec%0d_avg", i), Avg_o, vecs[i].exp_avg);
                check($sformatf("vec%0d_fill", i), Fill_o, vecs[i].exp_fill);
            end
        end

        // Backpressure: zero-filled window, then six back-to-back samples of 8 give averages 1..6.
        do_reset("bp");
        AvgReady_i = 1'b1;
        for (int i = 0; i < 8; i++) send(0);
        settle(3);
        check("bp_drained", AvgValid_o, 0);
        AvgReady_i = 1'b0;
        for (int i = 0; i < 6; i++) send(8);
        settle(2);
        check("bp_fill", Fill_o, 4);
        check("bp_ovf", Overflow_o, 1);
        check("bp_valid", AvgValid_o, 1);
        AvgReady_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("bp_drain%0d", i), Avg_o, i);
            check($sformatf("bp_ovf_hold%0d", i), Overflow_o, 1);
            @(negedge clk_100HZ);
        end
        check("bp_empty_valid", AvgValid_o, 0);
        check("bp_empty_avg", Avg_o, 0);
        check("bp_empty_fill", Fill_o, 0);
        check("bp_ovf_sticky", Overflow_o, 1);

        // Reset while holding an unconsumed average.
        AvgReady_i = 1'b0;
        send(8);
        settle(2);
        check("mid_valid", AvgValid_o, 1);
        check("mid_avg", Avg_o, 7);
        do_reset("mid");
`ifdef FRAC_COLLECT_WARMUP_EN
        for (int i = 1; i <= 7; i++) begin
            send(ONE);
            settle(2);
            check($sformatf("mid_warm%0d_valid", i), AvgValid_o, 0);
        end
        send(ONE);
        settle(2);
        check("mid_refill_valid", AvgValid_o, 1);
        check("mid_refill_avg", Avg_o, ONE);
`else
        send(ONE);
        settle(2);
        check("nowarm_valid", AvgValid_o, 1);
        check("nowarm_avg", Avg_o, 2097152);
        check("nowarm_fill", Fill_o, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
